mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported 32-bit program/data memory between two requesters: the instruction-fetch sequencer (fetch port F) and the load/store/label-table unit (data port D).
- Issues at most one memory access per cycle.
- Gives D fixed priority, bounded by a starvation limit that protects F.
- Returns read data only to the port that issued the read.
- Sits between the fetch sequencer/execution stage and the memory macro.

Parameters:
ADDR_W, 16, address width
DATA_W, 32, data width
RD_LATENCY, 1, cycles from memory sampling mem_addr to mem_rdata valid (1..4)
STARVE_LIMIT, 4, consecutive D grants allowed while F is waiting (1..15)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
halt  in  1  1 = issue no new grants; in-flight reads still complete
f_req  in  1  fetch read request; held with f_addr until f_ack
f_addr  in  ADDR_W  fetch address
f_ack  out  1  one-cycle pulse: F request issued to memory
f_rvalid  out  1  one-cycle pulse: f_rdata valid
f_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ack  out  1  one-cycle pulse: D request issued
d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only)
d_rdata  out  DATA_W  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 while any read is in flight

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, starvation counter 0, read-return tag pipeline cleared. Any in-flight read is dropped and produces no rvalid.
- All outputs are registered.
- Eligibility at posedge N:
  - F is eligible if f_req=1, f_ack=0 and halt=0.
  - D is eligible if d_req=1, d_ack=0 and halt=0.
  - A port whose ack is currently high is not eligible. This prevents double-issue of a request the requester has not yet dropped.
- Selection at posedge N:
  - Only D eligible → D.
  - Only F eligible → F.
  - Both eligible → D if starve_cnt < STARVE_LIMIT, else F.
  - Neither eligible → no grant.
- Issue: after posedge N, for exactly one cycle:
  - mem_en=1.
  - mem_addr, mem_we, mem_wdata come from the selected port; F always issues mem_we=0.
  - That port's ack=1.
  - With no grant: mem_en=0, mem_we=0, mem_addr/mem_wdata hold their previous values.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - +1 when D is granted while F is eligible.
  - Cleared when F is granted or when F is not requesting.
  - Otherwise holds.
- Read return:
  - Each read pushes its owner tag (F or D) into a pipeline of depth RD_LATENCY+1. Writes push an empty tag.
  - At posedge N+1+RD_LATENCY the arbiter captures mem_rdata into the owner's rdata register and pulses that owner's rvalid for one cycle.
  - rdata holds its value until the next rvalid for that port.
  - With RD_LATENCY=1: request sampled at edge 0 → ack high in cycle 0–1 → rvalid high in cycle 2–3.
- Back-to-back issue: one issue per cycle, alternating ports when both are continuously requesting. A single port can issue at most every other cycle.
- Writes complete on d_ack; no rvalid is generated.
- halt=1: no grant, starve_cnt holds, pending tags drain normally. A request held across halt is granted on the first edge after halt falls.
- busy = OR of the pipeline's read tags.
- A change of f_addr/d_addr while req=1 and ack=0 is legal; the value at the grant edge is used.

Test Plan:
- Reset: hold reset=0 with f_req=d_req=1 → all outputs 0. Release reset → first grant goes to D (d_ack), not F.
- Single fetch read, f_addr=0x0010, mem returns 0xDEADBEEF:
  - f_ack after edge 0, mem_addr=0x0010, mem_en=1.
  - f_rvalid=1, f_rdata=0xDEADBEEF after edge 2.
  - busy=1 for cycles 0–2.
- Contention, STARVE_LIMIT=4, both requesters re-requesting immediately:
  - Grant order D,F,D,F… (ack cooldown alternation).
  - Separately, with a D stream that never drops d_req: F is granted no later than the 5th eligible edge.
- Write then read on D (write 0x12345678 at 0x0020, then read 0x0020, memory model):
  - No d_rvalid for the write.
  - d_rvalid with 0x12345678 for the read.
  - f_rvalid never pulses.
- halt: assert halt with f_req=1 and a D read in flight → no new ack, D read's d_rvalid still arrives. Deassert halt → f_ack on the next edge.
- Reset mid-read: reset=0 one cycle after f_ack → f_rvalid never asserts, busy=0 immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch (F) and
// data (D) requesters. D has fixed priority, capped by a starvation counter.
// Ports:
//   clk, reset (async, active-low), halt    - clock, reset, grant freeze
//   f_req/f_addr -> f_ack/f_rvalid/f_rdata  - fetch read port
//   d_req/d_we/d_addr/d_wdata
//     -> d_ack/d_rvalid/d_rdata             - data read/write port
//   mem_en/mem_we/mem_addr/mem_wdata,
//     mem_rdata                             - memory macro side
//   busy                                    - any read still in flight
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // tag bit 1 = fetch read, bit 0 = data read; writes carry no tag
    logic [RD_LATENCY:0][1:0] tag_q, tag_d;

    logic              f_ack_q, f_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              f_rvalid_q, f_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic [3:0]        starve_q, starve_d;

    logic       f_elig, d_elig;
    logic       grant_f, grant_d;
    logic [1:0] ret_tag;

    // A port whose ack is high is still holding the request it was
    // just granted, so it sits out one edge.
    always_comb begin
        f_elig  = f_req && !f_ack_q && !halt;
        d_elig  = d_req && !d_ack_q && !halt;
        grant_d = d_elig && (!f_elig || (starve_q < LIMIT));
        grant_f = f_elig && !grant_d;
    end

    always_comb begin
        f_ack_d     = grant_f;
        d_ack_d     = grant_d;
        mem_en_d    = grant_f || grant_d;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (1'b1)
            grant_d: begin
                mem_we_d    = d_we;
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
            end
            grant_f: begin
                mem_addr_d  = f_addr;
            end
            default: ;
        endcase

        starve_d = starve_q;
        if (halt) begin
            starve_d = starve_q;
        end else if (grant_f || !f_req) begin
            starve_d = 4'd0;
        end else if (grant_d && f_elig && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end

        tag_d[0] = {grant_f, grant_d && !d_we};
        for (int i = 1; i <= RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // oldest stage lines up with mem_rdata on this edge
        ret_tag    = tag_q[RD_LATENCY];
        f_rvalid_d = ret_tag[1];
        d_rvalid_d = ret_tag[0];
        f_rdata_d  = ret_tag[1] ? mem_rdata : f_rdata_q;
        d_rdata_d  = ret_tag[0] ? mem_rdata : d_rdata_q;

        busy_d = |tag_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q       <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            tag_q       <= tag_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_rvalid_q  <= f_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            starve_q    <= starve_d;
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_rvalid  = f_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences
// for the fetch/data memory arbiter, with a 1-cycle sync memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks;
    int failures;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sync memory: samples mem_* on the edge after issue, data next cycle
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct packed {
        logic        halt;
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [15:0] d_addr;
        logic [31:0] d_wdata;
    } vin_t;

    typedef struct packed {
        logic        f_ack;
        logic        d_ack;
        logic        mem_en;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        f_rvalid;
        logic [31:0] f_rdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        busy;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] WV  = 32'h12345678;
    localparam logic [31:0] A30 = 32'hA0000030;
    localparam logic [31:0] A31 = 32'hA0000031;
    localparam logic [31:0] A40 = 32'hA0000040;
    localparam logic [31:0] A41 = 32'hA0000041;
    localparam logic [31:0] A50 = 32'hA0000050;
    localparam logic [31:0] A60 = 32'hA0000060;

    function automatic vin_t vi(logic h, logic fr, logic [15:0] fa,
                                logic dr, logic dw, logic [15:0] da,
                                logic [31:0] dd);
        vin_t v;
        v.halt = h; v.f_req = fr; v.f_addr = fa;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        return v;
    endfunction

    function automatic vout_t vo(logic fa, logic da, logic en, logic we,
                                 logic [15:0] ma, logic [31:0] mw,
                                 logic frv, logic [31:0] frd,
                                 logic drv, logic [31:0] drd, logic bz);
        vout_t v;
        v.f_ack = fa; v.d_ack = da; v.mem_en = en; v.mem_we = we;
        v.mem_addr = ma; v.mem_wdata = mw;
        v.f_rvalid = frv; v.f_rdata = frd;
        v.d_rvalid = drv; v.d_rdata = drd; v.busy = bz;
        return v;
    endfunction

    function automatic vout_t cur();
        vout_t v;
        v.f_ack = f_ack; v.d_ack = d_ack; v.mem_en = mem_en;
        v.mem_we = mem_we; v.mem_addr = mem_addr; v.mem_wdata = mem_wdata;
        v.f_rvalid = f_rvalid; v.f_rdata = f_rdata;
        v.d_rvalid = d_rvalid; v.d_rdata = d_rdata; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic apply(input vin_t v);
        halt    = v.halt;
        f_req   = v.f_req;
        f_addr  = v.f_addr;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vin_t idle;
        int   got_at;
        int   d_cnt;
        int   fr_cnt;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] <= 32'hA0000000 | 32'(i);
        mem[16] <= DB;
        idle = vi(0, 0, 0, 0, 0, 0, 0);

        // single fetch read
        vt[0]  = '{vi(0,1,16'h10,0,0,0,0),   vo(1,0,1,0,16'h10,0,0,0,0,0,1)};
        vt[1]  = '{vi(0,0,16'h10,0,0,0,0),   vo(0,0,0,0,16'h10,0,0,0,0,0,1)};
        vt[2]  = '{idle,                     vo(0,0,0,0,16'h10,0,1,DB,0,0,0)};
        vt[3]  = '{idle,                     vo(0,0,0,0,16'h10,0,0,DB,0,0,0)};
        // D write then read back
        vt[4]  = '{vi(0,0,0,1,1,16'h20,WV),  vo(0,1,1,1,16'h20,WV,0,DB,0,0,0)};
        vt[5]  = '{vi(0,0,0,1,0,16'h20,0),   vo(0,0,0,0,16'h20,WV,0,DB,0,0,0)};
        vt[6]  = '{vi(0,0,0,1,0,16'h20,0),   vo(0,1,1,0,16'h20,0,0,DB,0,0,1)};
        vt[7]  = '{idle,                     vo(0,0,0,0,16'h20,0,0,DB,0,0,1)};
        vt[8]  = '{idle,                     vo(0,0,0,0,16'h20,0,0,DB,1,WV,0)};
        vt[9]  = '{idle,                     vo(0,0,0,0,16'h20,0,0,DB,0,WV,0)};
        // contention: D,F,D,F
        vt[10] = '{vi(0,1,16'h30,1,0,16'h40,0), vo(0,1,1,0,16'h40,0,0,DB,0,WV,1)};
        vt[11] = '{vi(0,1,16'h30,1,0,16'h41,0), vo(1,0,1,0,16'h30,0,0,DB,0,WV,1)};
        vt[12] = '{vi(0,1,16'h31,1,0,16'h41,0), vo(0,1,1,0,16'h41,0,0,DB,1,A40,1)};
        vt[13] = '{vi(0,1,16'h31,0,0,0,0),      vo(1,0,1,0,16'h31,0,1,A30,0,A40,1)};
        vt[14] = '{idle,                        vo(0,0,0,0,16'h31,0,0,A30,1,A41,1)};
        vt[15] = '{idle,                        vo(0,0,0,0,16'h31,0,1,A31,0,A41,0)};
        vt[16] = '{idle,                        vo(0,0,0,0,16'h31,0,0,A31,0,A41,0)};
        // halt with D read in flight
        vt[17] = '{vi(0,0,0,1,0,16'h50,0),      vo(0,1,1,0,16'h50,0,0,A31,0,A41,1)};
        vt[18] = '{vi(1,1,16'h60,0,0,0,0),      vo(0,0,0,0,16'h50,0,0,A31,0,A41,1)};
        vt[19] = '{vi(1,1,16'h60,0,0,0,0),      vo(0,0,0,0,16'h50,0,0,A31,1,A50,0)};
        vt[20] = '{vi(0,1,16'h60,0,0,0,0),      vo(1,0,1,0,16'h60,0,0,A31,0,A50,1)};
        vt[21] = '{idle,                        vo(0,0,0,0,16'h60,0,0,A31,0,A50,1)};
        vt[22] = '{idle,                        vo(0,0,0,0,16'h60,0,1,A60,0,A50,0)};

        reset = 1'b0;
        apply(idle);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            apply(vt[k].i);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", k), cur(), vt[k].o);
        end

        // reset with both requesting, then D wins first
        @(negedge clk);
        reset = 1'b0;
        apply(vi(0, 1, 16'h70, 1, 0, 16'h71, 0));
        #1;
        chk("reset_outs", cur(), '0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_hold", cur(), '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first_grant_d", {d_ack, f_ack, mem_addr}, {1'b1, 1'b0, 16'h71});
        @(negedge clk);
        d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("then_grant_f", {f_ack, mem_addr}, {1'b1, 16'h70});
        @(negedge clk);
        apply(idle);
        repeat (4) @(negedge clk);

        // D stream never drops d_req; F must still get in
        apply(vi(0, 1, 16'h90, 1, 0, 16'h80, 0));
        got_at = 0;
        d_cnt  = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (d_ack) d_cnt++;
            if (e == 1) chk("stream_d_first", {d_ack, f_ack}, 2'b10);
            if (f_ack && got_at == 0) got_at = e;
            @(negedge clk);
            if (got_at != 0) f_req = 1'b0;
        end
        chk("stream_f_within_5", (got_at >= 1 && got_at <= 5), 1'b1);
        chk("stream_d_acks", d_cnt, 4);
        apply(idle);
        repeat (4) @(negedge clk);

        // reset one cycle after f_ack drops the read
        apply(vi(0, 1, 16'h10, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("midrd_ack", f_ack, 1'b1);
        @(negedge clk);
        f_req = 1'b0;
        @(posedge clk);
        #1;
        chk("midrd_busy_pre", busy, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("midrd_busy_rst", {busy, f_rvalid}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        fr_cnt = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            if (f_rvalid) fr_cnt++;
        end
        chk("midrd_no_rvalid", fr_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
